sram_b_14abits_arb: RTL and testbench
=====================================

# sram_b_14abits_arb

Round-robin arbiter that shares one 16K x 8 one-write/one-read SRAM bank (14-bit address, byte-wide data, per-bit write mask) among `NREQ` requesters. Each cycle it issues at most one write on the memory write port and at most one read on the memory read port. It prevents same-address write/read collisions, which the memory forbids, and routes read data back to the issuing requester one cycle later. It sits between accelerator-local PLM clients and the SRAM wrapper.

## Interface
- `NREQ`, 4: number of requesters, legal range 2..8.
- `IDW`, 2: requester index width, equal to clog2(`NREQ`).
- `CLK` in 1: single clock; all logic is on its rising edge.
- `RSTN` in 1: reset, asynchronous, active-low.
- `req_valid` in `NREQ`: request present, one bit per requester.
- `req_ready` out `NREQ`: request accepted this cycle.
- `req_write` in `NREQ`: 1 = write, 0 = read.
- `req_addr` in `NREQ`*14: packed; requester i uses bits [14i+13:14i].
- `req_wdata` in `NREQ`*8: packed write data.
- `req_wmask` in `NREQ`*8: packed per-bit write enable.
- `rsp_valid` out `NREQ`: read data valid for requester i.
- `rsp_rdata` out 8: read data, shared by all requesters; qualified by `rsp_valid`.
- `mem_CE0`, `mem_WE0` out 1: write-port enable and write strobe.
- `mem_A0` out 14: write-port address.
- `mem_D0` out 8: write-port data.
- `mem_WEM0` out 8: write-port bit mask.
- `mem_CE1` out 1: read-port enable.
- `mem_A1` out 14: read-port address.
- `mem_Q1` in 8: read data, valid one cycle after `mem_CE1`.

## Operation
- **Request classes:** a request with `req_write`=1 is a write candidate; with `req_write`=0 it is a read candidate. The two classes are arbitrated independently by two round-robin arbiters.
- **Handshake:** valid/ready. Once `req_valid[i]` is high, `req_write[i]`, `req_addr`, `req_wdata` and `req_wmask` for slot i stay stable until `req_ready[i]` is seen. `req_ready` depends combinationally on `req_valid`. At most one write grant and one read grant per cycle.
- **Round robin:** each arbiter has an `IDW`-bit pointer `wptr`/`rptr`, reset to 0. Search order is ptr, ptr+1, ..., wrapping modulo `NREQ`. After a grant to i, the pointer becomes (i+1) mod `NREQ`. The pointer is unchanged when there is no grant.
- **Memory drive, write grant i:** `mem_CE0`=`mem_WE0`=1, and `mem_A0`/`mem_D0`/`mem_WEM0` come from slot i.
- **Memory drive, read grant j:** `mem_CE1`=1, `mem_A1` = addr j.
- **Memory drive, idle port:** CE, WE, address, data and mask are all driven 0.
- **Collision rule:** a collision is a write winner and a read winner with equal addresses.
  - If `rd_prio`=0: the write issues, the read is held (not ready, `rptr` unchanged), and `rd_prio` is set to 1.
  - If `rd_prio`=1: the read issues, the write is held (`wptr` unchanged), and `rd_prio` is cleared.
  - `rd_prio` is also cleared on any cycle a read issues.
  - This alternation guarantees no starvation.
- **Response:** registered `rsp_id` and `rsp_pend` capture the read grant. The next cycle, `rsp_valid[rsp_id]`=1 and `rsp_rdata` = `mem_Q1`. Responses cannot be back-pressured.
- **Back-to-back reads** from the same requester are legal every cycle; responses return in issue order.

## Timing
- **Reset values:** `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0 (forced 0 while `rsp_pend`=0), all `mem_*` outputs 0, `wptr`=`rptr`=0, `rd_prio`=0.
- **Write latency:** 0 cycles to the memory port (same cycle as handshake). Data is readable by a read granted the following cycle or later.
- **Read latency:** `rsp_valid` exactly 1 cycle after the `req_ready` of the read.
- **Simultaneous write and read,** different addresses: both issue in the same cycle.
- **Reset asserted mid-operation:** a pending response is dropped, and `rsp_valid` falls asynchronously.
- **No requests:** all enables stay 0, and pointers and `rd_prio` hold.

## Test plan
- **Reset:** `RSTN`=0 with all `req_valid`=1 -> all outputs 0. After release, requester 0 is granted first in each class.
- **Write fairness:** 4 writers valid continuously for 8 cycles -> grants in order 0,1,2,3,0,1,2,3, and `mem_A0` follows each requester's address.
- **Write then read:** write addr 0x1234 data 0xA5 mask 0xFF from req 1; next cycle read 0x1234 from req 2 -> `rsp_valid`=4'b0100 one cycle later with `rsp_rdata`=0xA5.
- **Parallel issue:** req 0 writes 0x0010 while req 3 reads 0x3FFF in the same cycle -> both ready, `mem_CE0`=`mem_CE1`=1.
- **Collision alternation:** req 0 writes 0x0100 continuously while req 1 reads 0x0100 continuously -> issue pattern write, read, write, read. Never `mem_CE0`&`mem_CE1` with equal addresses.
- **Reset mid-read:** read granted, then `RSTN` pulsed low before the next edge -> no `rsp_valid`, and pointers return to 0.

Source files
------------

// File: rtl/sram_b_14abits_arb.sv
// Round-robin arbiter sharing one 1W/1R 16K x 8 SRAM bank among NREQ requesters.
// Separate write/read arbiters; same-address collisions alternate via rd_prio.
module sram_b_14abits_arb #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = 2
) (
   input  logic                 CLK,
   input  logic                 RSTN,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ-1:0]      req_write,
   input  logic [NREQ*14-1:0]   req_addr,
   input  logic [NREQ*8-1:0]    req_wdata,
   input  logic [NREQ*8-1:0]    req_wmask,
   output logic [NREQ-1:0]      rsp_valid,
   output logic [7:0]           rsp_rdata,
   output logic                 mem_CE0,
   output logic                 mem_WE0,
   output logic [13:0]          mem_A0,
   output logic [7:0]           mem_D0,
   output logic [7:0]           mem_WEM0,
   output logic                 mem_CE1,
   output logic [13:0]          mem_A1,
   input  logic [7:0]           mem_Q1
);

   logic [NREQ-1:0] wcand, rcand;
   logic [IDW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
   logic [IDW-1:0]  wsel, rsel, rsp_id_q;
   logic            wfound, rfound, collide, w_issue, r_issue;
   logic            rd_prio_q, rd_prio_d, rsp_pend_q;
   logic [13:0]     waddr, raddr;

   assign wcand = req_valid & req_write;
   assign rcand = req_valid & ~req_write;

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         rd_prio_q  <= 1'b0;
         rsp_pend_q <= 1'b0;
         rsp_id_q   <= '0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         rd_prio_q  <= rd_prio_d;
         rsp_pend_q <= r_issue;
         rsp_id_q   <= rsel;
      end
   end

   // First candidate at or after each pointer, wrapping modulo NREQ.
   always_comb begin
      logic [IDW:0] wsum, rsum;
      wsel   = '0;
      rsel   = '0;
      wfound = 1'b0;
      rfound = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         wsum = {1'b0, wptr_q} + (IDW+1)'(k);
         rsum = {1'b0, rptr_q} + (IDW+1)'(k);
         if (wsum >= (IDW+1)'(NREQ)) wsum = wsum - (IDW+1)'(NREQ);
         if (rsum >= (IDW+1)'(NREQ)) rsum = rsum - (IDW+1)'(NREQ);
         if (!wfound && wcand[wsum[IDW-1:0]]) begin
            wfound = 1'b1;
            wsel   = wsum[IDW-1:0];
         end
         if (!rfound && rcand[rsum[IDW-1:0]]) begin
            rfound = 1'b1;
            rsel   = rsum[IDW-1:0];
         end
      end
   end

   assign waddr   = req_addr[14*wsel +: 14];
   assign raddr   = req_addr[14*rsel +: 14];
   assign collide = wfound && rfound && (waddr == raddr);
   // On a collision rd_prio picks the side that issues; the other waits a cycle.
   assign w_issue = RSTN && wfound && !(collide && rd_prio_q);
   assign r_issue = RSTN && rfound && !(collide && !rd_prio_q);

   always_comb begin
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      rd_prio_d = rd_prio_q;
      if (w_issue) wptr_d = (wsel == IDW'(NREQ-1)) ? '0 : wsel + 1'b1;
      if (r_issue) rptr_d = (rsel == IDW'(NREQ-1)) ? '0 : rsel + 1'b1;
      if (r_issue)                 rd_prio_d = 1'b0;
      else if (collide && w_issue) rd_prio_d = 1'b1;
   end

   always_comb begin
      req_ready = '0;
      if (w_issue) req_ready = req_ready | (NREQ'(1) << wsel);
      if (r_issue) req_ready = req_ready | (NREQ'(1) << rsel);
      mem_CE0  = w_issue;
      mem_WE0  = w_issue;
      mem_A0   = w_issue ? waddr : '0;
      mem_D0   = w_issue ? req_wdata[8*wsel +: 8] : '0;
      mem_WEM0 = w_issue ? req_wmask[8*wsel +: 8] : '0;
      mem_CE1  = r_issue;
      mem_A1   = r_issue ? raddr : '0;
      rsp_valid = rsp_pend_q ? (NREQ'(1) << rsp_id_q) : '0;
      rsp_rdata = rsp_pend_q ? mem_Q1 : '0;
   end

endmodule

// File: tb/tb_sram_b_14abits_arb.sv
// Directed bench for sram_b_14abits_arb with an SRAM model and a response scoreboard.
module tb_sram_b_14abits_arb;

   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic                CLK = 1'b0;
   logic                RSTN;
   logic [NREQ-1:0]     req_valid, req_ready, req_write, rsp_valid;
   logic [NREQ*14-1:0]  req_addr;
   logic [NREQ*8-1:0]   req_wdata, req_wmask;
   logic [7:0]          rsp_rdata, mem_D0, mem_WEM0, mem_Q1;
   logic                mem_CE0, mem_WE0, mem_CE1;
   logic [13:0]         mem_A0, mem_A1;

   logic [7:0]  mem_model [0:16383];
   logic [7:0]  q_model;
   logic [11:0] exp_q [$];
   logic [11:0] mon_e;
   int          total = 0;
   int          bad   = 0;
   logic [3:0]  rr_seq [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                               4'b0001, 4'b0010, 4'b0100, 4'b1000};

   sram_b_14abits_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
      .CLK(CLK), .RSTN(RSTN),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .mem_CE0(mem_CE0), .mem_WE0(mem_WE0), .mem_A0(mem_A0), .mem_D0(mem_D0),
      .mem_WEM0(mem_WEM0), .mem_CE1(mem_CE1), .mem_A1(mem_A1), .mem_Q1(mem_Q1)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      if (mem_CE0 && mem_WE0)
         mem_model[mem_A0] <= (mem_model[mem_A0] & ~mem_WEM0) | (mem_D0 & mem_WEM0);
      if (mem_CE1) q_model <= mem_model[mem_A1];
   end
   assign mem_Q1 = q_model;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops an expected response whenever the DUT presents one.
   always @(negedge CLK) begin
      if (mem_CE0 && mem_CE1) chk("no_same_addr", {31'b0, mem_A0 == mem_A1}, 32'd0);
      if (rsp_valid != '0) begin
         if (exp_q.size() == 0) chk("unexpected_rsp", {28'b0, rsp_valid}, 32'd0);
         else begin
            mon_e = exp_q.pop_front();
            chk("rsp_valid", {28'b0, rsp_valid}, {28'b0, mon_e[11:8]});
            chk("rsp_rdata", {24'b0, rsp_rdata}, {24'b0, mon_e[7:0]});
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_slot(input int i, input logic [13:0] a, input logic [7:0] d,
                           input logic [7:0] m);
      req_addr[14*i +: 14] = a;
      req_wdata[8*i +: 8]  = d;
      req_wmask[8*i +: 8]  = m;
   endtask

   task automatic expect_cycle(input string tag, input logic [3:0] rdy, input logic ce0,
                               input logic [13:0] a0, input logic [7:0] d0,
                               input logic [7:0] wem, input logic ce1,
                               input logic [13:0] a1);
      @(negedge CLK);
      chk({tag, "_ready"}, {28'b0, req_ready}, {28'b0, rdy});
      chk({tag, "_ce0we0"}, {30'b0, mem_CE0, mem_WE0}, {30'b0, ce0, ce0});
      chk({tag, "_a0"}, {18'b0, mem_A0}, {18'b0, a0});
      chk({tag, "_d0wem0"}, {16'b0, mem_D0, mem_WEM0}, {16'b0, d0, wem});
      chk({tag, "_ce1"}, {31'b0, mem_CE1}, {31'b0, ce1});
      chk({tag, "_a1"}, {18'b0, mem_A1}, {18'b0, a1});
   endtask

   initial begin
      for (int i = 0; i < 16384; i++) mem_model[i] = 8'h00;
      q_model   = 8'h00;
      RSTN      = 1'b0;
      req_valid = '1;
      req_write = 4'b0011;
      for (int i = 0; i < NREQ; i++) set_slot(i, 14'h2000 + 14'(i), 8'h10 + 8'(i), 8'hFF);

      // Reset with every request present.
      @(negedge CLK);
      @(negedge CLK);
      chk("rst_ready", {28'b0, req_ready}, 32'd0);
      chk("rst_mem_ctl", {1'b0, mem_CE0, mem_WE0, mem_CE1, mem_A0, mem_A1}, 32'd0);
      chk("rst_mem_data", {16'b0, mem_D0, mem_WEM0}, 32'd0);
      chk("rst_rsp", {20'b0, rsp_valid, rsp_rdata}, 32'd0);
      tick();
      RSTN      = 1'b1;
      req_write = 4'b1111;

      // Write fairness.
      for (int c = 0; c < 8; c++) begin
         expect_cycle("wr_rr", rr_seq[c], 1'b1, 14'h2000 + 14'(c % 4), 8'h10 + 8'(c % 4),
                      8'hFF, 1'b0, 14'h0);
         tick();
      end

      // Write then read the same address.
      req_valid = 4'b0010; req_write = 4'b0010;
      set_slot(1, 14'h1234, 8'hA5, 8'hFF);
      expect_cycle("wtr_w", 4'b0010, 1'b1, 14'h1234, 8'hA5, 8'hFF, 1'b0, 14'h0);
      tick();
      req_valid = 4'b0100; req_write = 4'b0000;
      set_slot(2, 14'h1234, 8'h00, 8'h00);
      expect_cycle("wtr_r", 4'b0100, 1'b0, 14'h0, 8'h0, 8'h0, 1'b1, 14'h1234);
      exp_q.push_back({4'b0100, 8'hA5});
      tick();
      req_valid = 4'b0000;
      expect_cycle("idle", 4'b0000, 1'b0, 14'h0, 8'h0, 8'h0, 1'b0, 14'h0);
      tick();

      // Parallel issue, partial mask.
      req_valid = 4'b1001; req_write = 4'b0001;
      set_slot(0, 14'h0010, 8'h3C, 8'h0F);
      set_slot(3, 14'h3FFF, 8'h00, 8'h00);
      expect_cycle("par", 4'b1001, 1'b1, 14'h0010, 8'h3C, 8'h0F, 1'b1, 14'h3FFF);
      exp_q.push_back({4'b1000, 8'h00});
      tick();
      req_valid = 4'b0001; req_write = 4'b0000;
      expect_cycle("mask_rd", 4'b0001, 1'b0, 14'h0, 8'h0, 8'h0, 1'b1, 14'h0010);
      exp_q.push_back({4'b0001, 8'h0C});
      tick();

      // Collision alternation.
      req_valid = 4'b0011; req_write = 4'b0001;
      set_slot(0, 14'h0100, 8'h5A, 8'hFF);
      set_slot(1, 14'h0100, 8'h00, 8'h00);
      expect_cycle("col1_w", 4'b0001, 1'b1, 14'h0100, 8'h5A, 8'hFF, 1'b0, 14'h0);
      tick();
      set_slot(0, 14'h0100, 8'h77, 8'hFF);
      expect_cycle("col2_r", 4'b0010, 1'b0, 14'h0, 8'h0, 8'h0, 1'b1, 14'h0100);
      exp_q.push_back({4'b0010, 8'h5A});
      tick();
      expect_cycle("col3_w", 4'b0001, 1'b1, 14'h0100, 8'h77, 8'hFF, 1'b0, 14'h0);
      tick();
      expect_cycle("col4_r", 4'b0010, 1'b0, 14'h0, 8'h0, 8'h0, 1'b1, 14'h0100);
      exp_q.push_back({4'b0010, 8'h77});
      tick();

      // Reset pulse while a read response is pending.
      req_valid = 4'b0100; req_write = 4'b0000;
      set_slot(2, 14'h0100, 8'h00, 8'h00);
      expect_cycle("mid_rd", 4'b0100, 1'b0, 14'h0, 8'h0, 8'h0, 1'b1, 14'h0100);
      tick();
      chk("mid_pend_valid", {28'b0, rsp_valid}, {28'b0, 4'b0100});
      chk("mid_pend_rdata", {24'b0, rsp_rdata}, {24'b0, 8'h77});
      req_valid = 4'b0000;
      RSTN      = 1'b0;
      #1;
      chk("mid_rst_rsp", {20'b0, rsp_valid, rsp_rdata}, 32'd0);
      #1;
      RSTN = 1'b1;
      expect_cycle("post_rst", 4'b0000, 1'b0, 14'h0, 8'h0, 8'h0, 1'b0, 14'h0);
      tick();

      // Both pointers are back at requester 0.
      req_valid = 4'b1111; req_write = 4'b0000;
      for (int i = 0; i < NREQ; i++) set_slot(i, 14'h0200 + 14'(i), 8'h99, 8'hFF);
      expect_cycle("rptr0", 4'b0001, 1'b0, 14'h0, 8'h0, 8'h0, 1'b1, 14'h0200);
      exp_q.push_back({4'b0001, 8'h00});
      tick();
      req_write = 4'b1111;
      expect_cycle("wptr0", 4'b0001, 1'b1, 14'h0200, 8'h99, 8'hFF, 1'b0, 14'h0);
      tick();
      req_valid = 4'b0000;
      tick();
      tick();
      chk("rsp_drained", exp_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
